// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for a single regfile write port, with a lock that keeps multi-beat writebacks back-to-back.
// Optional grant/stall statistics counters are enabled by defining REGFILE_WB_ARB_STATS_EN.
module regfile_wb_arbiter #(
    parameter int width_p           = 32,
    parameter int els_p             = 32,
    parameter int num_req_p         = 4,
    parameter int x0_tied_to_zero_p = 1,
    localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int ptr_width_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic                                    stall_i,
    input  logic [num_req_p-1:0]                    req_v_i,
    input  logic [num_req_p-1:0]                    req_last_i,
    input  logic [num_req_p-1:0][addr_width_lp-1:0] req_addr_i,
    input  logic [num_req_p-1:0][width_p-1:0]       req_data_i,
    output logic [num_req_p-1:0]                    req_yumi_o,
    output logic                                    w_v_o,
    output logic [addr_width_lp-1:0]                w_addr_o,
    output logic [width_p-1:0]                      w_data_o,
`ifdef REGFILE_WB_ARB_STATS_EN
    output logic [num_req_p-1:0][31:0]              stat_grants_o,
    output logic [31:0]                             stat_stall_o,
`endif
    output logic                                    locked_o
);

    typedef enum logic {ARB, LOCK} state_e;

    state_e                   state_q, state_d;
    logic [ptr_width_lp-1:0]  ptr_q, ptr_d;
    logic [ptr_width_lp-1:0]  owner_q, owner_d;
    logic [ptr_width_lp-1:0]  grant_idx;
    logic [ptr_width_lp-1:0]  cand;
    int unsigned              scan_idx;
    logic                     grant_v;

    logic                     w_v_q, w_v_d;
    logic [addr_width_lp-1:0] w_addr_q, w_addr_d;
    logic [width_p-1:0]       w_data_q, w_data_d;
    logic [addr_width_lp-1:0] sel_addr;
    logic [width_p-1:0]       sel_data;
    logic                     drop_x0;

    function automatic logic [ptr_width_lp-1:0] incr_ptr(input logic [ptr_width_lp-1:0] p);
        return (32'(p) == 32'(num_req_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Scan from the farthest offset down so the nearest valid requester to ptr_q wins.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        grant_v   = 1'b0;
        grant_idx = '0;
        cand      = '0;
        scan_idx  = 0;
        unique case (state_q)
            ARB: begin
                if (!stall_i) begin
                    for (int k = num_req_p - 1; k >= 0; k--) begin
                        scan_idx = 32'(ptr_q) + 32'(k);
                        if (scan_idx >= 32'(num_req_p)) begin
                            scan_idx = scan_idx - 32'(num_req_p);
                        end
                        cand = ptr_width_lp'(scan_idx);
                        if (req_v_i[cand]) begin
                            grant_v   = 1'b1;
                            grant_idx = cand;
                        end
                    end
                    if (grant_v) begin
                        if (req_last_i[grant_idx]) begin
                            ptr_d = incr_ptr(grant_idx);
                        end else begin
                            owner_d = grant_idx;
                            state_d = LOCK;
                        end
                    end
                end
            end
            LOCK: begin
                if (!stall_i && req_v_i[owner_q]) begin
                    grant_v   = 1'b1;
                    grant_idx = owner_q;
                    if (req_last_i[owner_q]) begin
                        ptr_d   = incr_ptr(owner_q);
                        state_d = ARB;
                    end
                end
            end
        endcase
    end

    always_comb begin
        req_yumi_o = '0;
        if (grant_v && reset_n_i) begin
            req_yumi_o[grant_idx] = 1'b1;
        end
    end

    assign sel_addr = req_addr_i[grant_idx];
    assign sel_data = req_data_i[grant_idx];
    assign drop_x0  = (x0_tied_to_zero_p != 0) && (sel_addr == '0);

    // x0 beats are still consumed; only the regfile write is suppressed.
    always_comb begin
        w_v_d    = grant_v && !drop_x0;
        w_addr_d = grant_v ? sel_addr : w_addr_q;
        w_data_d = grant_v ? sel_data : w_data_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ARB;
            ptr_q    <= '0;
            owner_q  <= '0;
            w_v_q    <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            w_v_q    <= w_v_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

    assign w_v_o    = w_v_q;
    assign w_addr_o = w_addr_q;
    assign w_data_o = w_data_q;
    assign locked_o = (state_q == LOCK);

`ifdef REGFILE_WB_ARB_STATS_EN
    logic [num_req_p-1:0][31:0] grants_q;
    logic [31:0]                stall_cnt_q;

    // Saturating counters: they stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            grants_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < num_req_p; i++) begin
                if (req_yumi_o[i] && (grants_q[i] != '1)) begin
                    grants_q[i] <= grants_q[i] + 32'd1;
                end
            end
            if (stall_i && (|req_v_i) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign stat_grants_o = grants_q;
    assign stat_stall_o  = stall_cnt_q;
`endif

endmodule
